// File: rtl/ks_seq_mul_if.sv
// ----------------------------------------------------------------------------
// ks_seq_mul_if
// Streaming handshake bundle for the digit-serial GF(2)[x] multiplier.
//   in_valid / in_ready : operand handshake (producer -> multiplier)
//   a, b                : N-bit operands, bit i = coefficient of x^i
//   out_valid / out_ready: result handshake (multiplier -> consumer)
//   d                   : 2N-1 bit product (reduced form in d[N-1:0] when
//                         the multiplier is built with reduction)
//   busy                : multiplier is not idle
// Modports: master = operand producer / result consumer, slave = multiplier.
// ----------------------------------------------------------------------------
interface ks_seq_mul_if #(
  parameter int N = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-2:0]   d;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, busy
  );
endinterface

// File: rtl/ks_seq_mul.sv
// ----------------------------------------------------------------------------
// ks_seq_mul
// Digit-serial carry-less (GF(2)[x]) multiplier d = a * b. Operand b is
// consumed D bits per cycle, most significant digit first, with a Horner
// accumulation acc <- (acc << D) ^ (a * digit).
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ks_seq_mul_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/d,
//            busy)
//
// Parameters: N operand width, D digit width, POLY field polynomial (N+1 bits).
//
// Build option: define KS_SEQ_MUL_REDUCE_EN to add a REDUCE state that folds
// the product modulo POLY before presenting it (latency K+1 instead of K).
// Without it POLY is unused and d is the full unreduced product.
// ----------------------------------------------------------------------------
module ks_seq_mul #(
  parameter int         N    = 11,
  parameter int         D    = 4,
  parameter logic [N:0] POLY = 12'h805
) (
  input  logic         clk,
  input  logic         rst_n,
  ks_seq_mul_if.slave  bus
);

  localparam int K     = (N + D - 1) / D;   // number of digits
  localparam int KD    = K * D;             // padded width of b
  localparam int ACC_W = N + KD - 1;        // accumulator width
  localparam int PW    = N + D - 1;         // width of a * digit
  localparam int CW    = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_r;
  logic [N-1:0]      a_r;
  logic [KD-1:0]     b_r;       // shifts left so the current digit is on top
  logic [ACC_W-1:0]  acc_r;
  logic [CW-1:0]     cnt_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              busy_r;
  logic [2*N-2:0]    d_r;

  logic [D-1:0]      digit_s;
  logic [ACC_W-1:0]  acc_next_s;

  // Carry-less N x D product: XOR of shifted copies of x.
  function automatic logic [PW-1:0] clmul_digit(input logic [N-1:0] x,
                                                input logic [D-1:0] y);
    logic [PW-1:0] p;
    p = '0;
    for (int j = 0; j < D; j++) begin
      if (y[j]) begin
        p = p ^ (PW'(x) << j);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // Reduce a 2N-1 bit product modulo POLY, top bit first; the result has
  // bits [2N-2:N] cleared.
  function automatic logic [2*N-2:0] reduce_poly(input logic [2*N-2:0] x);
    logic [2*N-2:0] t;
    t = x;
    for (int i = 2*N-2; i >= N; i--) begin
      if (t[i]) begin
        t = t ^ ((2*N-1)'(POLY) << (i - N));
      end else begin
        t = t;
      end
    end
    return t;
  endfunction

  // One Horner step using the most significant remaining digit of b.
  always_comb begin
    digit_s    = b_r[KD-1 -: D];
    acc_next_s = (acc_r << D) ^ ACC_W'(clmul_digit(a_r, digit_s));
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      d_r         <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= KD'(bus.b);    // zero-pad b to K*D bits
            acc_r      <= '0;
            cnt_r      <= CNT_LAST;
            state_r    <= BUSY;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        BUSY: begin
          acc_r <= acc_next_s;
          b_r   <= b_r << D;
          if (cnt_r == '0) begin
`ifdef KS_SEQ_MUL_REDUCE_EN
            state_r <= REDUCE;
`else
            // Padding keeps bits >= 2N-1 zero, so the low slice is exact.
            d_r         <= acc_next_s[2*N-2:0];
            out_valid_r <= 1'b1;
            state_r     <= DONE;
`endif
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end

`ifdef KS_SEQ_MUL_REDUCE_EN
        REDUCE: begin
          d_r         <= reduce_poly(acc_r[2*N-2:0]);
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
`endif

        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end

        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.d         = d_r;

endmodule

// File: doc/ks_seq_mul.md
Name: ks_seq_mul

Overview:
- Digit-serial, parametrised GF(2)[x] polynomial multiplier: next generation of the fixed-width combinational Karatsuba multipliers.
- Computes d = a·b (carry-less) for N-bit operands, consuming D bits of b per cycle.
- Trades area for latency and adds valid/ready handshaking so it can sit directly in streaming datapaths.
- Optionally reduces the product modulo a field polynomial.

Parameters:
- N, 11, operand width in bits (N ≥ 2).
- D, 4, digit width processed per cycle (1 ≤ D ≤ N).
- POLY, 12'h805, field polynomial (N+1 bits, bit N must be 1; default x^11+x^2+1). Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands a, b valid.
- in_ready  out  1  block can accept operands.
- a  in  N  multiplicand, bit i = coefficient of x^i.
- b  in  N  multiplier.
- out_valid  out  1  d holds a completed result.
- out_ready  in  1  consumer accepts d.
- d  out  2N-1  product coefficients (reduced form in d[N-1:0] when the feature is enabled).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; busy=0; d=0; internal accumulator, operand registers and digit counter are cleared.
- K = ceil(N/D). b is zero-padded at the top to K·D bits, giving digits b_{K-1}..b_0.
- States: IDLE → BUSY → DONE → IDLE, plus REDUCE when the feature is enabled.
- IDLE: in_ready=1. Acceptance (in_valid & in_ready at an edge) latches a and the padded b, clears acc, sets cnt=K-1 and moves to BUSY. in_valid while not ready is ignored; a and b are don't-care.
- BUSY: in_ready=0. Each edge performs a Horner step, MSB digit first: acc ← (acc << D) ^ (a ⊗ b_cnt), where ⊗ is the carry-less N×D product (N+D-1 bits, XOR of shifted copies of a). The step at cnt=0 is the last; the next state is DONE, or REDUCE with the feature.
- Width rule: acc is N+K·D-1 bits. Bits at 2N-1 and above must be zero at completion (padding guarantees this); d = acc[2N-2:0].
- Latency: out_valid rises K edges after the acceptance edge (K+1 with the feature). Defaults: 3 (4).
- DONE: out_valid=1, and d is stable until the handshake. The edge with out_ready=1 returns the block to IDLE with out_valid=0. d keeps its last value until the next result is loaded. No input is accepted in DONE.
- Throughput: one result per K+2 cycles, assuming out_ready is held high.
- out_ready while out_valid=0 has no effect.
- D=N: K=1, a single BUSY cycle.
- Reset mid-operation (any state): in-flight transaction is dropped, all outputs return to their reset values, and no spurious out_valid is produced.
- busy = (state != IDLE).

Optional Feature:
- Macro KS_SEQ_MUL_REDUCE_EN.
- Defined: after BUSY, one REDUCE cycle computes r = acc mod POLY combinationally (unrolled over bits 2N-2 down to N). DONE presents d[N-1:0]=r and d[2N-2:N]=0. Latency K+1.
- Undefined: no REDUCE state; POLY is unused; d is the full unreduced product; latency K.

Test Plan:
- Identity (defaults): a=11'h001, b=11'h7FF, out_ready=1 → out_valid 3 cycles after acceptance, d=21'h0007FF; in_ready low for 4 cycles.
- Carry-less check: a=11'h003, b=11'h003 → d=21'h000005. a=b=11'h7FF → d=21'h155555.
- Backpressure: complete a=11'h003, b=11'h003 with out_ready=0 for 5 cycles while in_valid=1 with other data → d stays 21'h000005, in_ready=0, the second operand pair is not accepted; accepted only after the out_ready handshake and the return to IDLE.
- Parameter sweep: N=11 with D ∈ {1,3,4,11}; 1000 random pairs against a software carry-less model → exact match; latency = ceil(11/D).
- Reset mid-operation: assert rst_n=0 for 1 cycle during the 2nd BUSY cycle → out_valid=0, d=0, in_ready=1 immediately. The next transaction, a=11'h001, b=11'h7FF, gives d=21'h0007FF.
- With KS_SEQ_MUL_REDUCE_EN: a=11'h400, b=11'h002 → d=21'h000005, latency 4. Without the macro, the same operands → d=21'h000800, latency 3.
